// File: rtl/uart_irq_encoder.sv
// UART interrupt collector: sticky pending bits, enable masking and a fixed-priority
// binary ID that is held stable until the APB side acknowledges or the source withdraws.
module uart_irq_encoder #(
  parameter int NUM_SRC = 4,
  localparam int ID_W = $clog2(NUM_SRC)
) (
  input  logic               clk_i,
  input  logic               arst_ni,
  input  logic [NUM_SRC-1:0] src_i,
  input  logic [NUM_SRC-1:0] en_i,
  input  logic [NUM_SRC-1:0] clr_i,
  input  logic               ack_i,
  output logic [NUM_SRC-1:0] pend_o,
  output logic               irq_o,
  output logic               id_valid_o,
  output logic [ID_W-1:0]    id_o
);

  typedef enum logic {
    IDLE,
    HOLD
  } state_e;

  state_e             state_q, state_d;
  logic [ID_W-1:0]    id_q, id_d;
  logic [NUM_SRC-1:0] pend_q, pend_d;
  logic [NUM_SRC-1:0] active;
  logic [NUM_SRC-1:0] clear;
  logic [ID_W-1:0]    lowest_idx;
  logic               id_active;

  assign active = pend_q & en_i;

  // Scan from the top down so the lowest active index is the last one written.
  always_comb begin
    lowest_idx = '0;
    for (int k = NUM_SRC - 1; k >= 0; k--) begin
      if (active[k]) lowest_idx = ID_W'(k);
    end
  end

  // Decode the held ID once: it selects both the ack-clear bit and the withdraw check.
  always_comb begin
    id_active = 1'b0;
    clear     = clr_i;
    for (int k = 0; k < NUM_SRC; k++) begin
      if (id_q == ID_W'(k)) begin
        id_active = active[k];
        if ((state_q == HOLD) && ack_i) clear[k] = 1'b1;
      end
    end
  end

  assign pend_d = (pend_q & ~clear) | src_i;

  always_comb begin
    state_d = state_q;
    id_d    = id_q;
    case (state_q)
      IDLE: begin
        if (|active) begin
          id_d    = lowest_idx;
          state_d = HOLD;
        end
      end
      HOLD: begin
        // The ID stays frozen here; re-arbitration only happens back in IDLE.
        if (ack_i || !id_active) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge arst_ni) begin
    if (!arst_ni) begin
      state_q <= IDLE;
      id_q    <= '0;
      pend_q  <= '0;
    end else begin
      state_q <= state_d;
      id_q    <= id_d;
      pend_q  <= pend_d;
    end
  end

  assign pend_o     = pend_q;
  assign irq_o      = (state_q == HOLD);
  assign id_valid_o = (state_q == HOLD);
  assign id_o       = id_q;

endmodule
